// File: rtl/apb1_slave_dec.sv
// apb1_slave_dec: APB1 root-bus slave decoder and response mux with unmapped/timeout error completion.
// Optional timeout counter, forced completion and o_to_flag built when APB1_DEC_TIMEOUT_EN is defined.
module apb1_slave_dec #(
    parameter int          SLV_NUM = 8,
    parameter logic [15:0] BASE_HI = 16'h4000,
    parameter int          TO_CYC  = 255
) (
    input  logic                  i_hclk,
    input  logic                  i_hrst,
    input  logic                  i_pclk_en,
    input  logic                  i_root_psel,
    input  logic                  i_root_penable,
    input  logic [31:0]           i_root_paddr,
    output logic                  o_root_pready,
    output logic                  o_root_pslverr,
    output logic [31:0]           o_root_prdata,
    output logic [SLV_NUM-1:0]    o_slv_psel,
    output logic                  o_slv_penable,
    input  logic [SLV_NUM-1:0]    i_slv_pready,
    input  logic [SLV_NUM-1:0]    i_slv_pslverr,
    input  logic [32*SLV_NUM-1:0] i_slv_prdata,
    input  logic                  i_to_clr,
    output logic                  o_to_flag
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
    state_t      state_q, state_d;
    logic        hit_q, hit_d;
    logic [3:0]  idx_q, idx_d;
    logic [15:0] rdy_x, err_x;
    logic [31:0] rd_a [16];
    logic        live_hit, cur_hit, sel_ph, acc, go_setup, done, slv_rdy, forced;
    logic [3:0]  cur_idx;
    logic [20:0] unused_in;
    assign unused_in = {i_to_clr, 8'(TO_CYC), i_root_paddr[11:0]};
    assign rdy_x = 16'(i_slv_pready);
    assign err_x = 16'(i_slv_pslverr);
    for (genvar k = 0; k < 16; k++) begin : g_rd
        if (k < SLV_NUM) begin : g_on
            assign rd_a[k] = i_slv_prdata[32*k +: 32];
        end else begin : g_off
            assign rd_a[k] = '0;
        end
    end
    // In IDLE the bridge's SETUP cycle is decoded live so slave select has no added latency.
    assign live_hit = (i_root_paddr[31:16] == BASE_HI) && ({1'b0, i_root_paddr[15:12]} < 5'(SLV_NUM));
    assign cur_hit  = (state_q == IDLE) ? live_hit : hit_q;
    assign cur_idx  = (state_q == IDLE) ? i_root_paddr[15:12] : idx_q;
    assign sel_ph   = !i_hrst && i_root_psel && (state_q != IDLE || !i_root_penable);
    assign acc      = i_root_psel && i_root_penable && (state_q != IDLE);
    assign go_setup = (state_q == IDLE) && i_root_psel && !i_root_penable;
    assign slv_rdy  = rdy_x[cur_idx];
    assign done     = acc && i_pclk_en && o_root_pready;
    assign o_root_pready  = acc && (!hit_q || slv_rdy || forced);
    assign o_root_pslverr = acc && (!hit_q || forced || err_x[cur_idx]);
    assign o_root_prdata  = (acc && hit_q && !forced) ? rd_a[cur_idx] : '0;
    assign o_slv_psel     = (sel_ph && cur_hit && !forced) ? SLV_NUM'(1) << cur_idx : '0;
    assign o_slv_penable  = acc && hit_q && !forced;
    always_comb begin
        state_d = state_q;
        hit_d   = hit_q;
        idx_d   = idx_q;
        if (go_setup) begin
            state_d = SETUP;
            hit_d   = live_hit;
            idx_d   = i_root_paddr[15:12];
        end else if (state_q != IDLE && (!i_root_psel || done)) begin
            state_d = IDLE;
        end else if (state_q == SETUP && i_root_penable) begin
            state_d = ACCESS;
        end
    end
    always_ff @(posedge i_hclk or posedge i_hrst) begin
        if (i_hrst) begin
            state_q <= IDLE;
            hit_q   <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            hit_q   <= hit_d;
            idx_q   <= idx_d;
        end
    end
`ifdef APB1_DEC_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;
    logic       to_flag_q, to_flag_d;
    // A ready slave at the limit wins, so forcing needs the slave still stalled.
    assign forced    = acc && hit_q && !slv_rdy && (cnt_q == 8'(TO_CYC));
    assign cnt_d     = go_setup ? '0 :
                       (acc && i_pclk_en && hit_q && !slv_rdy && cnt_q != 8'hFF) ? cnt_q + 8'd1 : cnt_q;
    assign to_flag_d = (forced && i_pclk_en) || (to_flag_q && !i_to_clr);
    assign o_to_flag = to_flag_q;
    always_ff @(posedge i_hclk or posedge i_hrst) begin
        if (i_hrst) begin
            cnt_q     <= '0;
            to_flag_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            to_flag_q <= to_flag_d;
        end
    end
`else
    assign forced    = 1'b0;
    assign o_to_flag = 1'b0;
`endif
endmodule

// File: tb/tb_apb1_slave_dec.sv
// tb_apb1_slave_dec: bridge/slave stimulus with a transaction-level reference model of apb1_slave_dec.
module tb_apb1_slave_dec;
    localparam int TO = 4;
`ifdef APB1_DEC_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    logic         i_hclk = 1'b0, i_hrst = 1'b1, i_pclk_en = 1'b0;
    logic         i_root_psel = 1'b0, i_root_penable = 1'b0, i_to_clr = 1'b0;
    logic [31:0]  i_root_paddr = '0;
    logic         o_root_pready, o_root_pslverr, o_slv_penable, o_to_flag;
    logic [31:0]  o_root_prdata;
    logic [7:0]   o_slv_psel, i_slv_pready = '0, i_slv_pslverr = '0;
    logic [255:0] i_slv_prdata = '0;
    int           n_vec = 0, n_err = 0;
    logic         flag_m = 1'b0;

    apb1_slave_dec #(.SLV_NUM(8), .BASE_HI(16'h4000), .TO_CYC(TO)) dut (
        .i_hclk(i_hclk), .i_hrst(i_hrst), .i_pclk_en(i_pclk_en),
        .i_root_psel(i_root_psel), .i_root_penable(i_root_penable), .i_root_paddr(i_root_paddr),
        .o_root_pready(o_root_pready), .o_root_pslverr(o_root_pslverr), .o_root_prdata(o_root_prdata),
        .o_slv_psel(o_slv_psel), .o_slv_penable(o_slv_penable),
        .i_slv_pready(i_slv_pready), .i_slv_pslverr(i_slv_pslverr), .i_slv_prdata(i_slv_prdata),
        .i_to_clr(i_to_clr), .o_to_flag(o_to_flag)
    );

    always #5 i_hclk = ~i_hclk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic noise();
        i_slv_pready  = 8'($urandom);
        i_slv_pslverr = 8'($urandom);
        for (int s = 0; s < 8; s++) i_slv_prdata[32*s +: 32] = $urandom;
    endtask

    task automatic check_out(input logic [7:0] e_sel, input logic e_pen, input logic e_rdy,
                             input logic e_err, input logic [31:0] e_dat);
        chk("psel", o_slv_psel, e_sel);
        chk("penable", o_slv_penable, e_pen);
        chk("pready", o_root_pready, e_rdy);
        chk("pslverr", o_root_pslverr, e_err);
        chk("prdata", o_root_prdata, e_dat);
        chk("to_flag", o_to_flag, flag_m);
    endtask

    task automatic cyc(input logic pce, input logic [7:0] e_sel, input logic e_pen, input logic e_rdy,
                       input logic e_err, input logic [31:0] e_dat);
        i_pclk_en = pce;
        @(negedge i_hclk);
        check_out(e_sel, e_pen, e_rdy, e_err, e_dat);
        @(posedge i_hclk);
        #1;
    endtask

    task automatic idle(input logic clr);
        i_root_psel = 1'b0;
        i_root_penable = 1'b0;
        i_to_clr = clr;
        noise();
        cyc(1'b1, 8'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        i_to_clr = 1'b0;
        if (clr) flag_m = 1'b0;
    endtask

    // One bridge transfer: div hclk per PCLK, slave ready after wait_n access PCLKs.
    task automatic xfer(input logic [31:0] addr, input int wait_n, input logic [31:0] data,
                        input logic err, input int div);
        int slot, k;
        logic hit, rdy, forced, fin;
        logic [7:0] esel;
        slot = int'(addr[15:12]);
        hit  = (addr[31:16] == 16'h4000) && (slot < 8);
        esel = hit ? 8'(1 << slot) : 8'h0;
        i_root_psel = 1'b1;
        i_root_penable = 1'b0;
        i_root_paddr = addr;
        for (int c = 0; c < div; c++) begin
            noise();
            cyc(c == div - 1, esel, 1'b0, 1'b0, 1'b0, 32'h0);
        end
        i_root_penable = 1'b1;
        k = 0;
        fin = 1'b0;
        while (!fin) begin
            rdy    = k >= wait_n;
            forced = TO_EN && hit && !rdy && (k == TO);
            for (int c = 0; c < div; c++) begin
                noise();
                if (hit) begin
                    i_slv_pready[slot] = rdy;
                    i_slv_pslverr[slot] = err;
                    i_slv_prdata[32*slot +: 32] = data;
                end
                cyc(c == div - 1, forced ? 8'h0 : esel, hit && !forced, !hit || rdy || forced,
                    (hit && !forced) ? err : 1'b1, (hit && !forced) ? data : 32'h0);
            end
            if (forced) flag_m = 1'b1;
            fin = !hit || rdy || forced;
            k++;
        end
        idle(1'b0);
    endtask

    initial begin
        noise();
        #2;
        check_out(8'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        repeat (2) @(posedge i_hclk);
        #1;
        i_hrst = 1'b0;
        idle(1'b0);
        xfer(32'h4000_3010, 0, 32'hA5A5_1234, 1'b0, 1);
        xfer(32'h4000_0000, 3, 32'h1357_9BDF, 1'b0, 2);
        xfer(32'h5000_0000, 0, 32'h0, 1'b0, 1);
        xfer(32'h4000_9000, 0, 32'h0, 1'b0, 2);
        xfer(32'h4000_2000, 40, 32'hDEAD_BEEF, 1'b0, 1);
        idle(1'b0);
        idle(1'b1);
        idle(1'b0);
        xfer(32'h4000_2004, TO, 32'hCAFE_F00D, 1'b1, 2);
        xfer(32'h4000_2008, 40, 32'h0BAD_0BAD, 1'b0, 1);
        // Asynchronous reset in the middle of a stalled access.
        i_root_psel = 1'b1;
        i_root_penable = 1'b0;
        i_root_paddr = 32'h4000_2000;
        noise();
        cyc(1'b1, 8'h04, 1'b0, 1'b0, 1'b0, 32'h0);
        i_root_penable = 1'b1;
        noise();
        i_slv_pready[2] = 1'b0;
        i_slv_pslverr[2] = 1'b0;
        i_slv_prdata[95:64] = 32'h7777_0001;
        cyc(1'b1, 8'h04, 1'b1, 1'b0, 1'b0, 32'h7777_0001);
        @(negedge i_hclk);
        i_hrst = 1'b1;
        #1;
        flag_m = 1'b0;
        check_out(8'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        @(posedge i_hclk);
        #1;
        i_hrst = 1'b0;
        i_root_psel = 1'b0;
        i_root_penable = 1'b0;
        idle(1'b0);
        xfer(32'h4000_1004, 1, 32'h0123_4567, 1'b0, 1);
        for (int t = 0; t < 40; t++) begin
            int r;
            logic [31:0] a;
            r = $urandom_range(0, 9);
            a = {16'h4000, 4'($urandom_range(0, 7)), 12'($urandom)};
            if (r >= 7) a[15:12] = 4'($urandom_range(8, 15));
            if (r == 9) a[31:16] = 16'h4001 + 16'($urandom_range(0, 255));
            xfer(a, $urandom_range(0, 6), $urandom, 1'($urandom), $urandom_range(1, 3));
            if ($urandom_range(0, 3) == 0) idle(1'b1);
        end
        idle(1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
